// File: rtl/qdec_pkg.sv
// Shared types, phase constants and init length for the quadrature decoder.
// QDEC_GLITCH_FILTER_EN lengthens the init window to cover the input filter.
package qdec_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef logic [1:0] phase_t;

  // Phase order for upward motion, written as {a,b}: A leads B.
  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int INIT_CYCLES = 4;
`else
  localparam int INIT_CYCLES = 2;
`endif

  function automatic phase_t next_up(phase_t p);
    case (p)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic phase_t next_dn(phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_if.sv
// Encoder-input and position-output bundle of the quadrature decoder counter.
interface qdec_if #(parameter int N = 8);
  logic         a;
  logic         b;
  logic         en;
  logic         syn_clr;
  logic         load;
  logic [N-1:0] d;
  logic         err_clr;
  logic [N-1:0] q;
  logic         dir;
  logic         step_tick;
  logic         err_tick;
  logic         err_sticky;
  logic         max_tick;
  logic         min_tick;

  modport master (
    output a, b, en, syn_clr, load, d, err_clr,
    input  q, dir, step_tick, err_tick, err_sticky, max_tick, min_tick
  );

  modport slave (
    input  a, b, en, syn_clr, load, d, err_clr,
    output q, dir, step_tick, err_tick, err_sticky, max_tick, min_tick
  );
endinterface

// File: rtl/qdec_input_sync.sv
// Two-flop synchronizer for one encoder phase; with QDEC_GLITCH_FILTER_EN a
// stability filter follows that passes a level only after 3 identical samples.
module qdec_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic ff1, ff2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= din;
      ff2 <= ff1;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  logic h1, h2, held, stable;

  // Output follows ff2 as soon as the third matching sample is present, so the
  // filter adds two cycles rather than three.
  assign stable = (ff2 == h1) && (h1 == h2);
  assign dout   = stable ? ff2 : held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1   <= 1'b0;
      h2   <= 1'b0;
      held <= 1'b0;
    end else begin
      h1   <= ff2;
      h2   <= h1;
      held <= dout;
    end
  end
`else
  assign dout = ff2;
`endif

endmodule

// File: rtl/quad_decoder_counter.sv
// 4x quadrature decoder driving a wrapping N-bit position counter with error
// flags. Build with QDEC_GLITCH_FILTER_EN to add the input stability filter.
module quad_decoder_counter
  import qdec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic   clk,
  input  logic   reset,
  qdec_if.slave  bus
);

  localparam int           CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [N-1:0] ONE   = N'(1);
  localparam logic [N-1:0] QMAX  = {N{1'b1}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   init_cnt;
  logic               sa, sb;
  phase_t             s, prev;
  logic               decode_en;
  logic               step_up, step_dn, illegal, step_take;

  logic [N-1:0]       q;
  logic               dir, step_tick, err_tick, err_sticky;

  qdec_input_sync u_sync_a (.clk(clk), .reset(reset), .din(bus.a), .dout(sa));
  qdec_input_sync u_sync_b (.clk(clk), .reset(reset), .din(bus.b), .dout(sb));

  assign s = {sa, sb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      prev     <= PH_00;
    end else begin
      state <= state_nxt;
      prev  <= s;
      if (state == ST_INIT && init_cnt != CNT_W'(INIT_CYCLES))
        init_cnt <= init_cnt + CNT_W'(1);
    end
  end

  // INIT holds one edge past the count so prev captures a settled s after the
  // synchronizers have flushed their reset zeros.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    decode_en = 1'b0;
    case (state)
      ST_INIT: if (init_cnt == CNT_W'(INIT_CYCLES)) state_nxt = ST_RUN;
      ST_RUN:  decode_en = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    step_up   = decode_en && (s != prev) && (s == next_up(prev));
    step_dn   = decode_en && (s != prev) && (s == next_dn(prev));
    illegal   = decode_en && ((s ^ prev) == 2'b11);
    step_take = bus.en && !bus.syn_clr && !bus.load && (step_up || step_dn);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      dir        <= DIR_DN;
      step_tick  <= 1'b0;
      err_tick   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (bus.syn_clr)      q <= '0;
      else if (bus.load)    q <= bus.d;
      else if (step_take)   q <= step_up ? q + ONE : q - ONE;

      if (step_take) dir <= step_up ? DIR_UP : DIR_DN;

      step_tick <= step_take;
      err_tick  <= illegal;

      // A new error outranks a clear arriving in the same cycle.
      if (illegal)          err_sticky <= 1'b1;
      else if (bus.err_clr) err_sticky <= 1'b0;
    end
  end

  assign bus.q          = q;
  assign bus.dir        = dir;
  assign bus.step_tick  = step_tick;
  assign bus.err_tick   = err_tick;
  assign bus.err_sticky = err_sticky;
  assign bus.max_tick   = (q == QMAX);
  assign bus.min_tick   = (q == '0);

endmodule

// File: doc/quad_decoder_counter.md
# quad_decoder_counter

Quadrature decoder with an integrated N-bit position counter. It accepts the two-phase A/B signals of an incremental encoder, synchronizes and decodes them at 4x resolution, and steps a wrapping position register up or down. It also flags illegal transitions. It sits between encoder pins and application logic, with the same clear/load/tick controls as the team's universal counter.

## Interface
- N, 8, position counter width (≥2)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- a  in  1  encoder phase A, asynchronous to clk
- b  in  1  encoder phase B, asynchronous to clk
- en  in  1  count enable; when low, transitions are tracked but not counted
- syn_clr  in  1  synchronous clear of q
- load  in  1  synchronous load of d into q
- d  in  N  load value
- err_clr  in  1  clears err_sticky
- q  out  N  position count
- dir  out  1  direction of last counted step (1 = up)
- step_tick  out  1  one-cycle pulse when q changed due to a step
- err_tick  out  1  one-cycle pulse on illegal transition
- err_sticky  out  1  latched error flag
- max_tick  out  1  q == 2**N-1 (combinational)
- min_tick  out  1  q == 0 (combinational)

## Operation
- Each of a and b passes through a 2-FF synchronizer, giving s = {sa, sb}. A prev register holds the last decoded s.
- Control FSM has two states:
  - INIT: entered on reset. Lasts INIT_CYCLES clocks. prev <= s every cycle; no decoding.
  - RUN: entered after INIT. Decodes s vs prev every cycle; prev <= s every cycle.
- Up sequence ({a,b}): 00→10→11→01→00 (A leads B). The exact reverse is down. s == prev means no step.
- Both bits changed is illegal. It raises err_tick and sets err_sticky; q is unchanged.
- q update priority:
  1. syn_clr: q <= 0
  2. load: q <= d
  3. en & legal step: q <= q±1
- A step discarded by syn_clr, load or en=0 produces no step_tick and leaves dir unchanged. prev still advances.
- Arithmetic is modulo 2**N:
  - up from 2**N-1 → 0
  - down from 0 → 2**N-1
- err_sticky: set on illegal transition, cleared by err_clr. Set wins over simultaneous clear. syn_clr does not affect it.
- Reset values: q=0, dir=0, step_tick=0, err_tick=0, err_sticky=0. Synchronizers=0, prev=00, FSM=INIT. max_tick=0, min_tick=1 follow from q=0.
- Reset mid-operation aborts everything. Re-entering INIT prevents a false step or error from stale synchronizer contents.

## Timing
- a/b stable before clk edge t: s reflects it after edge t+1. q, dir, step_tick and err_tick update at edge t+2 (2-cycle latency).
- Registered outputs: step_tick, err_tick, dir and q are all registered.
- Minimum legal input edge spacing: 2 clk periods (4 with the filter). Closer edges may alias to an error.
- INIT_CYCLES = 2 (4 with the filter).

## Configuration
- QDEC_GLITCH_FILTER_EN defined:
  - Each synchronized phase feeds a stability filter. The filtered output changes only after 3 consecutive identical samples.
  - Adds 2 cycles: outputs update at edge t+4.
  - INIT_CYCLES = 4.
  - Single-cycle glitches are rejected and produce no step and no error.
- Not defined: no filter; 2-cycle latency as above.

## Structure
- Package qdec_pkg holds:
  - FSM state type (INIT, RUN)
  - phase-sequence constants and direction constants (DIR_UP=1, DIR_DN=0)
  - INIT_CYCLES derived from the macro
- Sub-module qdec_input_sync: 2-FF synchronizer plus the optional filter, instantiated once per phase.
- Decode, FSM and counter live in the top.

## Test plan
- Basic up count: reset, wait INIT, en=1, drive 4 full up cycles (16 edges, 4 clk spacing) → q=16, 16 step_tick pulses, dir=1, each step_tick 2 cycles after its edge.
- Wrap-around: load d=2**N-1, then one down edge → q=2**N-2. Up edges from 2**N-2 → 2**N-1 (max_tick=1), then 0 (min_tick=1). Down from 0 → 2**N-1.
- Illegal transition: from {a,b}=00 drive 11 → err_tick single pulse, err_sticky=1, q unchanged. err_clr asserted in the same cycle as a second illegal jump → err_sticky stays 1.
- Priority: syn_clr and load asserted together with a valid up step → q=0, no step_tick. load alone with d=0x55 plus a step → q=0x55.
- Reset with inputs high: hold a=b=1 through and after reset deassertion → no err_tick, no step_tick, q=0.
- Filter (macro on): 1-cycle pulse on a → no step. A 3-cycle-stable edge → step_tick at edge t+4.
